// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 12-bit instructions from a combinational ROM,
// reads operands from a 4 x 4-bit register file, drives an external registered
// ALU and writes its result back. One instruction every 5 cycles.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start                begin execution at address 0 (IDLE only)
//   ld_en/ld_addr/ld_data external register-file write (IDLE only)
//   prog_addr/prog_data  instruction ROM address (= pc) and word
//   in1/in0/cin/instr    registered ALU operand, carry and opcode drive
//   alu_out              registered ALU result
//   wb_en/wb_addr/wb_data one-cycle write-back strobe, destination, value
//   busy/done            high outside IDLE / one-cycle pulse in HALT
module instr_sequencer #(
  parameter int unsigned PC_W = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            ld_en,
  input  logic [1:0]      ld_addr,
  input  logic [3:0]      ld_data,
  output logic [PC_W-1:0] prog_addr,
  input  logic [11:0]     prog_data,
  output logic [3:0]      in1,
  output logic [3:0]      in0,
  output logic            cin,
  output logic [2:0]      instr,
  input  logic [3:0]      alu_out,
  output logic            wb_en,
  output logic [1:0]      wb_addr,
  output logic [3:0]      wb_data,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StEx1, StEx2, StWb, StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  // Instruction bits [11:2]; bits [1:0] carry no meaning and are dropped.
  logic [9:0]      ir_q;
  logic [3:0]      rf_q [4];
  logic [3:0]      in1_q, in0_q;
  logic            cin_q;
  logic [2:0]      instr_q;
  logic            wb_en_q;
  logic [1:0]      wb_addr_q;
  logic [3:0]      wb_data_q;

  logic [2:0] ir_op;
  logic [1:0] ir_dst, ir_src1, ir_src0;
  logic       ir_cin;
  logic       unused_prog_bits;

  assign ir_op            = ir_q[9:7];
  assign ir_dst           = ir_q[6:5];
  assign ir_src1          = ir_q[4:3];
  assign ir_src0          = ir_q[2:1];
  assign ir_cin           = ir_q[0];
  assign unused_prog_bits = ^prog_data[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = (ir_op == 3'b111) ? StHalt : StEx1;
      StEx1:    state_d = StEx2;
      StEx2:    state_d = StWb;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q      <= '0;
      ir_q      <= '0;
      in1_q     <= '0;
      in0_q     <= '0;
      cin_q     <= 1'b0;
      instr_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) pc_q <= '0;
          if (ld_en) rf_q[ld_addr] <= ld_data;
        end
        StFetch: ir_q <= prog_data[11:2];
        StDecode: begin
          // ALU drive stays frozen through EX1..WB; the ALU decodes the live instr.
          if (ir_op != 3'b111) begin
            in1_q   <= rf_q[ir_src1];
            in0_q   <= rf_q[ir_src0];
            cin_q   <= ir_cin;
            instr_q <= ir_op;
          end
        end
        StWb: begin
          rf_q[ir_dst] <= alu_out;
          wb_en_q      <= 1'b1;
          wb_addr_q    <= ir_dst;
          wb_data_q    <= alu_out;
          pc_q         <= pc_q + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign prog_addr = pc_q;
  assign in1       = in1_q;
  assign in0       = in0_q;
  assign cin       = cin_q;
  assign instr     = instr_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StHalt);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural ROM and registered ALU
// (001 = in1+in0+cin, 010 = in1+~in0+cin).
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, ld_en;
  logic [1:0]  ld_addr;
  logic [3:0]  ld_data;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic [3:0]  in1, in0;
  logic        cin;
  logic [2:0]  instr;
  logic [3:0]  alu_out;
  logic        wb_en;
  logic [1:0]  wb_addr;
  logic [3:0]  wb_data;
  logic        busy, done;

  logic [11:0] rom [16];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [11:0] Halt = 12'b111_00_00_00_0_00;

  instr_sequencer #(.PC_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .prog_addr(prog_addr), .prog_data(prog_data),
    .in1(in1), .in0(in0), .cin(cin), .instr(instr), .alu_out(alu_out),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign prog_data = rom[prog_addr];

  always_ff @(posedge clk) begin
    case (instr)
      3'b001:  alu_out <= in1 + in0 + {3'b000, cin};
      3'b010:  alu_out <= in1 + ~in0 + {3'b000, cin};
      default: alu_out <= 4'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ld(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Leaves the DUT in the FETCH cycle of the instruction at address 0.
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; ld_en = 1'b0; ld_addr = 2'd0; ld_data = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = Halt;
    tick(2);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_wb_en", 32'(wb_en), 32'h0);
    check("rst_prog_addr", 32'(prog_addr), 32'h0);
    check("rst_in1", 32'(in1), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    rstn = 1'b1;
    tick(2);
    check("idle_busy", 32'(busy), 32'h0);

    // ADD r3,r1,r2 with r1=5, r2=3, then HALT
    rom[0] = 12'b001_11_01_10_0_00;
    rom[1] = Halt;
    ld(2'd1, 4'd5);
    ld(2'd2, 4'd3);
    check("ld_r1", 32'(dut.rf_q[1]), 32'h5);
    check("ld_r2", 32'(dut.rf_q[2]), 32'h3);
    go();
    check("t1_fetch_busy", 32'(busy), 32'h1);
    check("t1_fetch_addr", 32'(prog_addr), 32'h0);
    tick(2);
    check("t1_in1", 32'(in1), 32'h5);
    check("t1_in0", 32'(in0), 32'h3);
    check("t1_instr", 32'(instr), 32'h1);
    tick(2);
    check("t1_wb_early", 32'(wb_en), 32'h0);
    tick();
    check("t1_wb_en", 32'(wb_en), 32'h1);
    check("t1_wb_addr", 32'(wb_addr), 32'h3);
    check("t1_wb_data", 32'(wb_data), 32'h8);
    check("t1_pc", 32'(prog_addr), 32'h1);
    tick();
    check("t1_wb_pulse", 32'(wb_en), 32'h0);
    tick();
    check("t1_done", 32'(done), 32'h1);
    check("t1_halt_busy", 32'(busy), 32'h1);
    check("t1_halt_in1", 32'(in1), 32'h5);
    check("t1_halt_instr", 32'(instr), 32'h1);
    tick();
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_idle_busy", 32'(busy), 32'h0);

    // 9+8 wraps to 1; next instruction reads the new r0
    rom[0] = 12'b001_00_01_10_0_00;
    rom[1] = 12'b001_01_00_00_0_00;
    rom[2] = Halt;
    ld(2'd1, 4'd9);
    ld(2'd2, 4'd8);
    go();
    tick(5);
    check("t2_wb_addr0", 32'(wb_addr), 32'h0);
    check("t2_wb_data0", 32'(wb_data), 32'h1);
    tick(5);
    check("t2_wb_en1", 32'(wb_en), 32'h1);
    check("t2_wb_addr1", 32'(wb_addr), 32'h1);
    check("t2_wb_data1", 32'(wb_data), 32'h2);
    tick(2);
    check("t2_done", 32'(done), 32'h1);
    tick();

    // SUB r2,r1,r2 cin1: operands held through EX1, EX2, WB
    rom[0] = 12'b010_10_01_10_1_00;
    rom[1] = Halt;
    ld(2'd1, 4'd5);
    ld(2'd2, 4'd3);
    go();
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t3_in1_c%0d", c), 32'(in1), 32'h5);
      check($sformatf("t3_in0_c%0d", c), 32'(in0), 32'h3);
      check($sformatf("t3_cin_c%0d", c), 32'(cin), 32'h1);
      check($sformatf("t3_instr_c%0d", c), 32'(instr), 32'h2);
    end
    tick();
    check("t3_wb_addr", 32'(wb_addr), 32'h2);
    check("t3_wb_data", 32'(wb_data), 32'h2);
    tick(3);

    // Reset during EX2 aborts the instruction
    rom[0] = 12'b001_11_01_10_0_00;
    go();
    tick(3);
    rstn = 1'b0;
    #1;
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_wb_en", 32'(wb_en), 32'h0);
    check("t4_wb_data", 32'(wb_data), 32'h0);
    check("t4_in1", 32'(in1), 32'h0);
    check("t4_instr", 32'(instr), 32'h0);
    check("t4_prog_addr", 32'(prog_addr), 32'h0);
    for (int r = 0; r < 4; r++) check($sformatf("t4_r%0d", r), 32'(dut.rf_q[r]), 32'h0);
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("t4_post_wb_c%0d", c), 32'(wb_en), 32'h0);
      check($sformatf("t4_post_busy_c%0d", c), 32'(busy), 32'h0);
    end
    ld(2'd1, 4'd1);
    ld(2'd2, 4'd1);
    go();
    check("t4_restart_addr", 32'(prog_addr), 32'h0);
    tick(5);
    check("t4_restart_wb_addr", 32'(wb_addr), 32'h3);
    check("t4_restart_wb_data", 32'(wb_data), 32'h2);
    tick(3);

    // start and ld_en while busy are ignored
    go();
    start = 1'b1; ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'hf;
    tick(5);
    check("t5_wb_en", 32'(wb_en), 32'h1);
    check("t5_wb_data", 32'(wb_data), 32'h2);
    tick(2);
    check("t5_done", 32'(done), 32'h1);
    start = 1'b0; ld_en = 1'b0;
    tick();
    check("t5_idle", 32'(busy), 32'h0);
    check("t5_r0", 32'(dut.rf_q[0]), 32'h0);

    // No HALT: ADD r0,r0,r1 forever, pc wraps 15 -> 0, start held high
    for (int i = 0; i < 16; i++) rom[i] = 12'b001_00_00_01_0_00;
    start = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      tick(5);
      check($sformatf("t6_wb_en_%0d", i), 32'(wb_en), 32'h1);
      check($sformatf("t6_wb_data_%0d", i), 32'(wb_data), 32'((i + 1) % 16));
      check($sformatf("t6_pc_%0d", i), 32'(prog_addr), 32'((i + 1) % 16));
    end
    check("t6_busy", 32'(busy), 32'h1);
    start = 1'b0;
    rstn = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 4: program-counter width; program space is 2^PC_W words.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin execution at address 0; sampled in IDLE only.
REQ-005 SHALL have port ld_en  input  1  external register-file write strobe; honoured in IDLE only.
REQ-006 SHALL have port ld_addr  input  2  register index for ld_en.
REQ-007 SHALL have port ld_data  input  4  data for ld_en.
REQ-008 SHALL have port prog_addr  output  PC_W  registered instruction-ROM address (= pc).
REQ-009 SHALL have port prog_data  input  12  instruction word; combinational ROM, valid in the same cycle as prog_addr.
REQ-010 SHALL have ports in1 output 4, in0 output 4, cin output 1 and instr output 3: ALU operand, carry and opcode drive, all registered.
REQ-011 SHALL have port alu_out  input  4  ALU registered result.
REQ-012 SHALL have ports wb_en output 1, wb_addr output 2 and wb_data output 4: one-cycle write-back strobe, destination and value.
REQ-013 SHALL have ports busy output 1 (high in every state except IDLE) and done output 1 (one-cycle pulse on HALT).

Function
REQ-014 SHALL decode the instruction word as: [11:9] op, [8:7] dst, [6:5] src1, [4:3] src0, [2] cin; bits [1:0] are ignored.
REQ-015 SHALL hold a 4-entry x 4-bit register file, r0..r3.
REQ-016 SHALL implement the FSM IDLE -> FETCH -> DECODE -> EX1 -> EX2 -> WB -> FETCH, with DECODE -> HALT -> IDLE.
REQ-017 IDLE: on start=1 SHALL set pc=0 and go to FETCH; on ld_en=1 SHALL write rf[ld_addr]=ld_data; start and ld_en in the same cycle SHALL perform both.
REQ-018 FETCH: SHALL latch prog_data into the internal instruction register.
REQ-019 DECODE, op != 111: SHALL register in1=rf[src1], in0=rf[src0], cin=bit 2 and instr=op, then go to EX1.
REQ-020 DECODE, op = 111: SHALL go to HALT without changing in1/in0/cin/instr and without a write-back.
REQ-021 SHALL hold in1, in0, cin and instr unchanged through EX1, EX2 and WB, because the ALU's output stage decodes the live instr.
REQ-022 WB: SHALL write rf[dst]=alu_out, assert wb_en=1 with wb_addr=dst and wb_data=alu_out, set pc=pc+1 modulo 2^PC_W (wrap to 0 from 2^PC_W-1), and go to FETCH.
REQ-023 Latency: wb_en SHALL assert exactly 5 cycles after the FETCH cycle of its instruction; throughput SHALL be one instruction per 5 cycles.
REQ-024 HALT: SHALL assert done=1 for exactly one cycle, then go to IDLE; busy SHALL be 1 during HALT.
REQ-025 SHALL ignore start and ld_en in every state other than IDLE.
REQ-026 SHALL assert wb_en and done only as stated above; both SHALL be 0 otherwise.
REQ-027 Register-file writes from WB SHALL be visible to the DECODE of the next instruction (read-after-write without hazard).

Reset
REQ-028 rstn=0 SHALL, asynchronously: force the FSM to IDLE; clear pc, prog_addr, in1, in0, cin, instr, wb_en, wb_addr, wb_data, busy, done, the instruction register and r0..r3 to 0.
REQ-029 Reset asserted mid-instruction SHALL abort it with no write-back, and no pending result SHALL appear after release.
REQ-030 After rstn deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-031 ld r1=5, r2=3; ROM[0]=ADD r3,r1,r2,cin0 (001_11_01_10_0_00), ROM[1]=HALT -> wb_en with wb_addr=3, wb_data=8 five cycles after FETCH; then done pulse; busy=0.
REQ-032 r1=9, r2=8, ADD r0,r1,r2,cin0 -> wb_data=1 (4-bit wrap); a following ADD r1,r0,r0 reads the new r0 and writes r1=2.
REQ-033 r1=5, r2=3, op=010 (SUB) r2,r1,r2,cin1 -> in1=5, in0=3, cin=1, instr=010 held stable for 3 cycles; wb_data=2.
REQ-034 rstn pulsed low during EX2 -> no wb_en, all outputs and r0..r3 read 0, FSM in IDLE; start after release runs from address 0.
REQ-035 start and ld_en (r0=F) pulsed while busy -> both ignored: r0 unchanged and execution uninterrupted.
REQ-036 PC_W=4, ROM[0..15] all ADD, no HALT -> prog_addr wraps 15 -> 0 and execution continues; start held high has no effect.
